// File: rtl/pc_fetch_stk.sv
// Fetch stage: owns the program counter and a 2-level return stack, registers the
// fetched word for decode and applies redirects/skips coming back from execute.
module pc_fetch_stk #(
    parameter int unsigned          PC_W      = 11,
    parameter int unsigned          INS_W     = 12,
    parameter logic [PC_W-1:0]      RESET_VEC = 11'h7FF,
    parameter logic [INS_W-1:0]     NOP_INS   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                br_goto,
    input  logic                br_call,
    input  logic                br_ret,
    input  logic                br_pcl,
    input  logic                skip,
    input  logic [8:0]          k9,
    input  logic [1:0]          pa,
    input  logic [7:0]          pcl_d,
    input  logic [INS_W-1:0]    ins_i,
    output logic [PC_W-1:0]     rom_addr,
    output logic [INS_W-1:0]    ins_o,
    output logic [PC_W-1:0]     pc_o,
    output logic [1:0]          stk_depth,
    output logic                stk_ovf,
    output logic                stk_unf
);

    typedef enum logic [2:0] {
        RD_NONE,
        RD_CALL,
        RD_GOTO,
        RD_RET,
        RD_PCL
    } redir_e;

    logic [PC_W-1:0]  r_pc;
    logic [INS_W-1:0] r_ins;
    logic [PC_W-1:0]  r_pc_o;
    logic [PC_W-1:0]  r_stk0;
    logic [PC_W-1:0]  r_stk1;
    logic [1:0]       r_depth;
    logic             r_ovf;
    logic             r_unf;

    redir_e           w_kind;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_pc_inc;

    // Simultaneous redirect requests resolve as call > goto > ret > pcl.
    always_comb begin
        w_kind = RD_NONE;
        if (br_call)
            w_kind = RD_CALL;
        else if (br_goto)
            w_kind = RD_GOTO;
        else if (br_ret)
            w_kind = RD_RET;
        else if (br_pcl)
            w_kind = RD_PCL;
    end

    always_comb begin
        w_target = r_pc;
        case (w_kind)
            RD_CALL: w_target = PC_W'({pa, 1'b0, k9[7:0]});
            RD_GOTO: w_target = PC_W'({pa, k9});
            RD_RET:  w_target = r_stk0;
            RD_PCL:  w_target = PC_W'({pa, 1'b0, pcl_d});
            default: w_target = r_pc;
        endcase
        w_pc_inc = r_pc + PC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_VEC;
            r_ins   <= NOP_INS;
            r_pc_o  <= '0;
            r_stk0  <= '0;
            r_stk1  <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!stall) begin
            r_pc_o <= r_pc;
            if (w_kind != RD_NONE) begin
                r_pc  <= w_target;
                r_ins <= NOP_INS;
                if (w_kind == RD_CALL) begin
                    // r_pc already points past the call, so it is the return address.
                    r_stk1 <= r_stk0;
                    r_stk0 <= r_pc;
                    if (r_depth == 2'd2)
                        r_ovf <= 1'b1;
                    else
                        r_depth <= r_depth + 2'd1;
                end else if (w_kind == RD_RET) begin
                    r_stk0 <= r_stk1;
                    if (r_depth == 2'd0)
                        r_unf <= 1'b1;
                    else
                        r_depth <= r_depth - 2'd1;
                end
            end else begin
                r_pc  <= w_pc_inc;
                r_ins <= skip ? NOP_INS : ins_i;
            end
        end
    end

    assign rom_addr  = r_pc;
    assign ins_o     = r_ins;
    assign pc_o      = r_pc_o;
    assign stk_depth = r_depth;
    assign stk_ovf   = r_ovf;
    assign stk_unf   = r_unf;

endmodule

// File: tb/tb_pc_fetch_stk.sv
// Bench for pc_fetch_stk: directed scenarios with literal expectations, plus a
// behavioural model compared against every output on every falling edge.
module tb_pc_fetch_stk;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_goto, br_call, br_ret, br_pcl, skip;
    logic [8:0]  k9;
    logic [1:0]  pa;
    logic [7:0]  pcl_d;
    logic [11:0] ins_i;
    logic [10:0] rom_addr;
    logic [11:0] ins_o;
    logic [10:0] pc_o;
    logic [1:0]  stk_depth;
    logic        stk_ovf, stk_unf;

    int n_chk  = 0;
    int n_fail = 0;

    pc_fetch_stk #(
        .PC_W      (11),
        .INS_W     (12),
        .RESET_VEC (11'h7FF),
        .NOP_INS   (12'h000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_goto   (br_goto),
        .br_call   (br_call),
        .br_ret    (br_ret),
        .br_pcl    (br_pcl),
        .skip      (skip),
        .k9        (k9),
        .pa        (pa),
        .pcl_d     (pcl_d),
        .ins_i     (ins_i),
        .rom_addr  (rom_addr),
        .ins_o     (ins_o),
        .pc_o      (pc_o),
        .stk_depth (stk_depth),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    // ROM content never equals the NOP word, so squashed slots are distinguishable.
    function automatic logic [11:0] rom(input logic [10:0] a);
        return {1'b1, a} ^ 12'h3C3;
    endfunction

    assign ins_i = rom(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program counter, instruction slot and a two-entry return stack.
    logic [10:0] m_pc, m_pc_o;
    logic [11:0] m_ins;
    logic [10:0] m_stk [2];
    int          m_depth;
    logic        m_ovf, m_unf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc     <= 11'h7FF;
            m_ins    <= 12'h000;
            m_pc_o   <= 11'h000;
            m_stk[0] <= 11'h000;
            m_stk[1] <= 11'h000;
            m_depth  <= 0;
            m_ovf    <= 1'b0;
            m_unf    <= 1'b0;
        end else if (!stall) begin
            m_pc_o <= m_pc;
            if (br_call) begin
                m_pc     <= {pa, 1'b0, k9[7:0]};
                m_ins    <= 12'h000;
                m_stk[1] <= m_stk[0];
                m_stk[0] <= m_pc;
                if (m_depth == 2) m_ovf <= 1'b1;
                else m_depth <= m_depth + 1;
            end else if (br_goto) begin
                m_pc  <= {pa, k9};
                m_ins <= 12'h000;
            end else if (br_ret) begin
                m_pc     <= m_stk[0];
                m_ins    <= 12'h000;
                m_stk[0] <= m_stk[1];
                if (m_depth == 0) m_unf <= 1'b1;
                else m_depth <= m_depth - 1;
            end else if (br_pcl) begin
                m_pc  <= {pa, 1'b0, pcl_d};
                m_ins <= 12'h000;
            end else begin
                m_pc  <= m_pc + 11'd1;
                m_ins <= skip ? 12'h000 : rom(m_pc);
            end
        end
    end

    always @(negedge clk) begin
        check("mdl_rom_addr",  32'(rom_addr),  32'(m_pc));
        check("mdl_ins_o",     32'(ins_o),     32'(m_ins));
        check("mdl_pc_o",      32'(pc_o),      32'(m_pc_o));
        check("mdl_stk_depth", 32'(stk_depth), 32'(m_depth));
        check("mdl_stk_ovf",   32'(stk_ovf),   32'(m_ovf));
        check("mdl_stk_unf",   32'(stk_unf),   32'(m_unf));
    end

    task automatic clear_in();
        stall = 0; br_goto = 0; br_call = 0; br_ret = 0; br_pcl = 0; skip = 0;
        k9 = '0; pa = '0; pcl_d = '0;
    endtask

    // Present one execute-stage event for a single edge, then return at the next falling edge.
    task automatic fire(input logic g, input logic c, input logic r, input logic p, input logic s,
                        input logic [1:0] pa_v, input logic [8:0] k_v, input logic [7:0] d_v);
        br_goto = g; br_call = c; br_ret = r; br_pcl = p; skip = s;
        pa = pa_v; k9 = k_v; pcl_d = d_v;
        @(negedge clk);
        clear_in();
    endtask

    task automatic jump(input logic [10:0] a);
        fire(1, 0, 0, 0, 0, a[10:9], a[8:0], 8'h00);
    endtask

    task automatic run_to(input logic [10:0] a);
        int unsigned n = 0;
        while (rom_addr !== a && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rom_addr !== a) check("run_to_timeout", 32'(rom_addr), 32'(a));
    endtask

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1;
        clear_in();
        repeat (3) @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'h7FF);
        check("rst_ins_o",    32'(ins_o),    32'h000);
        check("rst_pc_o",     32'(pc_o),     32'h000);
        check("rst_depth",    32'(stk_depth), 32'd0);

        // T1: sequential fetch with 7FF -> 000 wrap
        rst = 1'b0;
        @(negedge clk);
        check("t1_addr0", 32'(rom_addr), 32'h000);
        check("t1_ins0",  32'(ins_o),    32'hC3C);
        check("t1_pco0",  32'(pc_o),     32'h7FF);
        @(negedge clk);
        check("t1_addr1", 32'(rom_addr), 32'h001);
        check("t1_ins1",  32'(ins_o),    32'hBC3);

        // T2: goto with page bits
        run_to(11'h010);
        fire(1, 0, 0, 0, 0, 2'b01, 9'h055, 8'h00);
        check("t2_addr", 32'(rom_addr), 32'h255);
        check("t2_nop",  32'(ins_o),    32'h000);
        check("t2_pco",  32'(pc_o),     32'h010);
        @(negedge clk);
        check("t2_ins",  32'(ins_o),    32'h996);
        check("t2_pco2", 32'(pc_o),     32'h255);

        // T3: call / return
        jump(11'h01E);
        run_to(11'h021);
        fire(0, 1, 0, 0, 0, 2'b00, 9'h080, 8'h00);
        check("t3_call_addr",  32'(rom_addr),  32'h080);
        check("t3_call_depth", 32'(stk_depth), 32'd1);
        run_to(11'h085);
        fire(0, 0, 1, 0, 0, 2'b00, 9'h000, 8'h00);
        check("t3_ret_addr",  32'(rom_addr),  32'h021);
        check("t3_ret_depth", 32'(stk_depth), 32'd0);

        // T4: three nested calls overflow the two-entry stack
        jump(11'h00C);
        run_to(11'h010);
        fire(0, 1, 0, 0, 0, 2'b00, 9'h018, 8'h00);
        run_to(11'h020);
        fire(0, 1, 0, 0, 0, 2'b00, 9'h028, 8'h00);
        check("t4_no_ovf", 32'(stk_ovf), 32'd0);
        run_to(11'h030);
        fire(0, 1, 0, 0, 0, 2'b00, 9'h038, 8'h00);
        check("t4_ovf",   32'(stk_ovf),   32'd1);
        check("t4_depth", 32'(stk_depth), 32'd2);
        fire(0, 0, 1, 0, 0, 2'b00, 9'h000, 8'h00);
        check("t4_ret1", 32'(rom_addr), 32'h030);
        fire(0, 0, 1, 0, 0, 2'b00, 9'h000, 8'h00);
        check("t4_ret2",   32'(rom_addr),  32'h020);
        check("t4_depth0", 32'(stk_depth), 32'd0);
        check("t4_no_unf", 32'(stk_unf),   32'd0);
        fire(0, 0, 1, 0, 0, 2'b00, 9'h000, 8'h00);
        check("t4_ret3", 32'(rom_addr), 32'h020);
        check("t4_unf",  32'(stk_unf),  32'd1);

        // T5: skip squashes the fetched word but keeps sequential addressing
        jump(11'h03E);
        run_to(11'h040);
        fire(0, 0, 0, 0, 1, 2'b00, 9'h000, 8'h00);
        check("t5_addr", 32'(rom_addr), 32'h041);
        check("t5_nop",  32'(ins_o),    32'h000);
        check("t5_pco",  32'(pc_o),     32'h040);

        // T6: stall freezes a pending goto, then a PCL write
        run_to(11'h050);
        stall = 1; br_goto = 1; pa = 2'b00; k9 = 9'h123;
        repeat (3) begin
            @(negedge clk);
            check("t6_hold_addr", 32'(rom_addr), 32'h050);
            check("t6_hold_pco",  32'(pc_o),     32'h04F);
        end
        stall = 0;
        @(negedge clk);
        clear_in();
        check("t6_goto_addr", 32'(rom_addr), 32'h123);
        check("t6_goto_nop",  32'(ins_o),    32'h000);
        check("t6_goto_pco",  32'(pc_o),     32'h050);
        fire(0, 0, 0, 1, 0, 2'b11, 9'h000, 8'hA0);
        check("t6_pcl_addr", 32'(rom_addr), 32'h6A0);

        // Call wins over simultaneous goto and skip
        fire(1, 1, 0, 0, 1, 2'b00, 9'h155, 8'h00);
        check("prio_addr",  32'(rom_addr),  32'h055);
        check("prio_depth", 32'(stk_depth), 32'd1);

        // Asynchronous reset in the middle of a redirect
        br_goto = 1; k9 = 9'h1AB;
        #2 rst = 1'b1;
        #1;
        check("arst_addr", 32'(rom_addr),  32'h7FF);
        check("arst_ovf",  32'(stk_ovf),   32'd0);
        check("arst_unf",  32'(stk_unf),   32'd0);
        check("arst_dep",  32'(stk_depth), 32'd0);
        clear_in();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_rel_addr", 32'(rom_addr), 32'h000);
        check("arst_rel_pco",  32'(pc_o),     32'h7FF);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
